// File: rtl/demux1to4_reg_pkg.sv
// Shared lane constants and select decode for the registered 1-to-4 demultiplexer.
package demux1to4_reg_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] LANE_WB  = 2'd0;
  localparam logic [SEL_W-1:0] LANE_LSU = 2'd1;
  localparam logic [SEL_W-1:0] LANE_BR  = 2'd2;
  localparam logic [SEL_W-1:0] LANE_CSR = 2'd3;

  function automatic logic [LANES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [LANES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux1to4_reg_if.sv
// Producer-side and consumer-side handshake bundle of the 1-to-4 demultiplexer.
interface demux1to4_reg_if #(
  parameter int unsigned WIDTH = 32
);
  import demux1to4_reg_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       lane_busy;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, lane_busy
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, lane_busy
  );

endinterface

// File: rtl/demux1to4_reg_slot.sv
// One-entry output slot: a load wins over a drain so back-to-back words leave no bubble.
module demux1to4_reg_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Data reset is only for X-free simulation; function relies on the valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer: routes each accepted word to one of four independent
// single-entry lane slots; readiness depends only on the selected lane.
module demux1to4_reg
  import demux1to4_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  demux1to4_reg_if.slave bus
);

  logic [LANES-1:0] sel_oh;
  logic [LANES-1:0] load;
  logic [LANES-1:0] drain;
  logic [LANES-1:0] valid;
  logic             accept;

  always_comb begin
    sel_oh       = sel_onehot(bus.in_sel);
    // A full lane still accepts when its consumer is draining this cycle.
    bus.in_ready = ~valid[bus.in_sel] | bus.out_ready[bus.in_sel];
    accept       = bus.in_valid & bus.in_ready;
    load         = {LANES{accept}} & sel_oh;
    drain        = valid & bus.out_ready;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux1to4_reg_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .drain (drain[k]),
      .din   (bus.in_data),
      .valid (valid[k]),
      .dout  (bus.out_data[k*WIDTH +: WIDTH])
    );
  end

  assign bus.out_valid = valid;
  assign bus.lane_busy = valid & ~bus.out_ready;

endmodule

// File: tb/tb_demux1to4_reg.sv
// Directed bench for demux1to4_reg; a negedge monitor keeps one expected-word queue per lane.
module tb_demux1to4_reg;
  import demux1to4_reg_pkg::*;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [W-1:0] expq[LANES][$];

  demux1to4_reg_if #(.WIDTH(W)) bus ();

  demux1to4_reg #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] lane_data(input int k);
    logic [LANES*W-1:0] all;
    all = bus.out_data;
    return all[k*W +: W];
  endfunction

  // Scoreboard monitor: compare, then retire drained words, then record accepted words.
  always @(negedge clk) begin
    logic [LANES-1:0] mv;
    logic             exp_rdy;
    for (int k = 0; k < LANES; k++) mv[k] = (expq[k].size() != 0);
    for (int k = 0; k < LANES; k++) begin
      chk($sformatf("mon_valid%0d", k), W'(bus.out_valid[k]), W'(mv[k]));
      chk($sformatf("mon_busy%0d", k), W'(bus.lane_busy[k]), W'(mv[k] & ~bus.out_ready[k]));
      if (mv[k]) chk($sformatf("mon_data%0d", k), lane_data(k), expq[k][0]);
    end
    exp_rdy = ~mv[bus.in_sel] | bus.out_ready[bus.in_sel];
    chk("mon_in_ready", W'(bus.in_ready), W'(exp_rdy));
    if (rst) begin
      for (int k = 0; k < LANES; k++) expq[k].delete();
    end else begin
      for (int k = 0; k < LANES; k++)
        if (mv[k] && bus.out_ready[k]) void'(expq[k].pop_front());
      if (bus.in_valid && exp_rdy) expq[bus.in_sel].push_back(bus.in_data);
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic drive(input logic [SEL_W-1:0] sel, input logic [W-1:0] data);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    #1;
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    // 1: reset held two cycles with a word offered
    rst           = 1'b1;
    bus.out_ready = 4'b1111;
    drive(LANE_LSU, 32'hCAFE_0001);
    tick();
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_valid", W'(bus.out_valid), 32'h0);
    for (int k = 0; k < LANES; k++) chk($sformatf("rst_data%0d", k), lane_data(k), 32'h0);

    // 2: single route to lane 2
    drive(LANE_BR, 32'hDEAD_BEEF);
    tick();
    bus.in_valid = 1'b0;
    chk("single_valid", W'(bus.out_valid), 32'h4);
    chk("single_data", lane_data(2), 32'hDEAD_BEEF);
    tick();
    chk("single_clear", W'(bus.out_valid), 32'h0);

    // 3: backpressure on lane 1, then drain and reload in the same clock
    bus.out_ready = 4'b1101;
    drive(LANE_LSU, 32'h1);
    chk("bp_rdy1", W'(bus.in_ready), 32'h1);
    tick();
    drive(LANE_LSU, 32'h2);
    chk("bp_rdy2", W'(bus.in_ready), 32'h0);
    tick();
    chk("bp_hold", lane_data(1), 32'h1);
    chk("bp_still_blocked", W'(bus.in_ready), 32'h0);
    bus.out_ready = 4'b1111;
    #1;
    chk("bp_release_rdy", W'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_reload_valid", W'(bus.out_valid[1]), 32'h1);
    chk("bp_reload_data", lane_data(1), 32'h2);
    tick();
    chk("bp_empty", W'(bus.out_valid), 32'h0);

    // 4: lane 0 stalled full must not block lanes 1..3
    bus.out_ready = 4'b1110;
    drive(LANE_WB, 32'hA0A0_A0A0);
    tick();
    for (int k = 1; k < LANES; k++) begin
      drive(SEL_W'(k), 32'hB000_0000 + 32'(k));
      chk($sformatf("iso_rdy%0d", k), W'(bus.in_ready), 32'h1);
      tick();
      chk($sformatf("iso_valid%0d", k), W'(bus.out_valid[k]), 32'h1);
      chk($sformatf("iso_data%0d", k), lane_data(k), 32'hB000_0000 + 32'(k));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("iso_lane0_held", lane_data(0), 32'hA0A0_A0A0);
    chk("iso_only_lane0", W'(bus.out_valid), 32'h1);
    bus.out_ready = 4'b1111;
    tick();

    // 5: 16-beat stream to lane 3 at full rate
    for (int i = 0; i < 16; i++) begin
      drive(LANE_CSR, 32'h3000 + 32'(i));
      chk("stream_rdy", W'(bus.in_ready), 32'h1);
      tick();
      chk("stream_valid", W'(bus.out_valid[3]), 32'h1);
      chk("stream_data", lane_data(3), 32'h3000 + 32'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_end", W'(bus.out_valid), 32'h0);

    // 6: reset while lanes 0 and 2 hold stalled words
    bus.out_ready = 4'b1010;
    drive(LANE_WB, 32'h6000_0000);
    tick();
    drive(LANE_BR, 32'h6000_0002);
    tick();
    bus.in_valid = 1'b0;
    chk("mid_full", W'(bus.out_valid), 32'h5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_dropped", W'(bus.out_valid), 32'h0);
    chk("mid_data0", lane_data(0), 32'h0);
    bus.out_ready = 4'b1111;
    tick();
    tick();
    for (int k = 0; k < LANES; k++)
      chk($sformatf("sb_empty%0d", k), 32'(expq[k].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
